// File: rtl/prefetcher_pkg.sv
// Shared prefetcher types and helpers: stream-detector state encoding,
// block alignment and stride-range qualification.
package prefetcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRAIN  = 2'd2,
    LOCKED = 2'd3
  } stride_state_t;

  localparam int unsigned HELPER_W = 64;

  function automatic logic [HELPER_W-1:0] block_align(
    input logic [HELPER_W-1:0] addr,
    input int unsigned         log_bytes
  );
    return addr & ~((64'd1 << log_bytes) - 64'd1);
  endfunction

  // Nonzero delta whose magnitude fits within max_blocks whole blocks.
  function automatic logic stride_in_range(
    input logic signed [HELPER_W-1:0] d,
    input int unsigned                max_blocks,
    input int unsigned                log_bytes
  );
    logic [HELPER_W-1:0] du;
    logic [HELPER_W-1:0] mag;
    du  = d;
    mag = du[HELPER_W-1] ? (~du + 64'd1) : du;
    return (du != '0) && (mag <= (64'(max_blocks) << log_bytes));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter with synchronous clear and load; never wraps.
module sat_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != {WIDTH{1'b1}}) cnt_d = cnt_q + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stride_detector.sv
// Learns a constant block-aligned stride for one AXI ID and, once confident,
// publishes the stride and a running next-prefetch address.
module stride_detector
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS            = 64,
  parameter int unsigned TID_WIDTH            = 4,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
  parameter int unsigned CONF_BITS            = 2,
  parameter int unsigned CONF_THRESH          = 2,
  parameter int unsigned MAX_STRIDE_BLOCKS    = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 obs_valid,
  input  logic [ADDR_BITS-1:0] obs_addr,
  input  logic [TID_WIDTH-1:0] obs_id,
  input  logic                 pred_advance,
  output logic                 locked,
  output logic [ADDR_BITS-1:0] stride,
  output logic [ADDR_BITS-1:0] pred_addr,
  output logic [TID_WIDTH-1:0] ctx_id,
  output logic                 ctx_valid,
  output logic [CONF_BITS-1:0] conf
);

  stride_state_t        state_q, state_d;
  logic [ADDR_BITS-1:0] last_q, last_d;
  logic [ADDR_BITS-1:0] stride_q, stride_d;
  logic [ADDR_BITS-1:0] pred_q, pred_d;
  logic [TID_WIDTH-1:0] ctx_q, ctx_d;
  logic [CONF_BITS-1:0] conf_q;
  logic [CONF_BITS-1:0] conf_plus;
  logic                 conf_clr, conf_load, conf_inc, conf_dec;

  logic [ADDR_BITS-1:0] a;
  logic [ADDR_BITS-1:0] delta;
  logic                 same_id;
  logic                 d_zero;
  logic                 d_valid;
  logic                 d_match;

  assign a       = ADDR_BITS'(block_align(64'(obs_addr), LOG_BLOCK_DATA_BYTES));
  assign delta   = a - last_q;
  assign same_id = (obs_id == ctx_q);
  assign d_zero  = (delta == '0);
  assign d_valid = stride_in_range(64'(signed'(delta)), MAX_STRIDE_BLOCKS,
                                   LOG_BLOCK_DATA_BYTES);
  assign d_match = (delta == stride_q);
  assign conf_plus = (conf_q == {CONF_BITS{1'b1}}) ? conf_q : conf_q + CONF_BITS'(1);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    stride_d  = stride_q;
    pred_d    = pred_q;
    ctx_d     = ctx_q;
    conf_clr  = 1'b0;
    conf_load = 1'b0;
    conf_inc  = 1'b0;
    conf_dec  = 1'b0;

    if (flush) begin
      state_d  = IDLE;
      last_d   = '0;
      stride_d = '0;
      pred_d   = '0;
      ctx_d    = '0;
      conf_clr = 1'b1;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (obs_valid) begin
            state_d = FIRST;
            last_d  = a;
            ctx_d   = obs_id;
          end
        end
        FIRST: begin
          if (obs_valid) begin
            if (!same_id) begin
              last_d = a;
              ctx_d  = obs_id;
            end else if (d_valid) begin
              state_d   = TRAIN;
              stride_d  = delta;
              conf_load = 1'b1;
              last_d    = a;
            end else if (!d_zero) begin
              last_d = a;
            end
          end
        end
        TRAIN: begin
          if (obs_valid) begin
            if (!same_id || (!d_zero && !d_valid)) begin
              // Fall back to FIRST, forgetting the partially trained stride.
              state_d  = FIRST;
              last_d   = a;
              ctx_d    = obs_id;
              stride_d = '0;
              conf_clr = 1'b1;
            end else if (!d_zero && d_match) begin
              conf_inc = 1'b1;
              last_d   = a;
              if (conf_plus >= CONF_BITS'(CONF_THRESH)) begin
                state_d = LOCKED;
                pred_d  = a + stride_q;
              end
            end else if (!d_zero) begin
              stride_d  = delta;
              conf_load = 1'b1;
              last_d    = a;
            end
          end
        end
        LOCKED: begin
          if (pred_advance) pred_d = pred_q + stride_q;
          if (obs_valid && same_id) begin
            last_d = a;
            if (d_match) begin
              conf_inc = 1'b1;
            end else if (!d_zero) begin
              if (conf_q == CONF_BITS'(1)) begin
                // Confidence exhausted: unlock wins over any coincident advance.
                pred_d = '0;
                if (d_valid) begin
                  state_d   = TRAIN;
                  stride_d  = delta;
                  conf_load = 1'b1;
                end else begin
                  state_d  = FIRST;
                  stride_d = '0;
                  conf_clr = 1'b1;
                end
              end else begin
                conf_dec = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      last_q   <= '0;
      stride_q <= '0;
      pred_q   <= '0;
      ctx_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      stride_q <= stride_d;
      pred_q   <= pred_d;
      ctx_q    <= ctx_d;
    end
  end

  sat_counter #(
    .WIDTH (CONF_BITS)
  ) u_conf (
    .clk        (clk),
    .rst_n      (resetN),
    .clr_i      (conf_clr),
    .load_i     (conf_load),
    .load_val_i (CONF_BITS'(1)),
    .inc_i      (conf_inc),
    .dec_i      (conf_dec),
    .cnt_o      (conf_q)
  );

  assign locked    = (state_q == LOCKED);
  assign stride    = stride_q;
  assign pred_addr = pred_q;
  assign ctx_id    = ctx_q;
  assign ctx_valid = (state_q != IDLE);
  assign conf      = conf_q;

endmodule
